// File: rtl/cellrv32_npu_weight_receiver.sv
// ---------------------------------------------------------------------------
// cellrv32_npu_weight_receiver
//
// Receiving end of the NPU weight-load interface inside the matrix multiply
// unit. Weight rows streamed by the weight control unit are captured into a
// preweight bank. An activate command copies that bank into the active bank.
// During the copy, each byte is widened to 9 bits. The widening uses sign
// extension when the row was loaded as signed, and zero extension otherwise.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous reset, active-high, highest priority
//   enable_i         global stall; when low all state holds, inputs ignored
//   load_wei_i       a weight row is present this cycle
//   wei_addr_i       row index of the incoming weight row
//   wei_signed_i     row bytes are signed (1) or unsigned (0)
//   wei_data_i       row data, byte k -> column k
//   activate_i       copy the preweight bank into the active bank
//   active_wei_o     active weights, element (r,c) at bit (r*MW+c)*9
//   rows_loaded_o    per-row mask of rows written since the last activate
//   full_o           every row has been loaded since the last activate
//   activate_done_o  one-cycle pulse after the active bank was updated
//   addr_err_o       sticky flag, set by a load with an out-of-range row
// ---------------------------------------------------------------------------
module cellrv32_npu_weight_receiver #(
  parameter int MATRIX_WIDTH = 14
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    enable_i,
  input  logic                                    load_wei_i,
  input  logic [7:0]                              wei_addr_i,
  input  logic                                    wei_signed_i,
  input  logic [MATRIX_WIDTH*8-1:0]               wei_data_i,
  input  logic                                    activate_i,
  output logic [MATRIX_WIDTH*MATRIX_WIDTH*9-1:0]  active_wei_o,
  output logic [MATRIX_WIDTH-1:0]                 rows_loaded_o,
  output logic                                    full_o,
  output logic                                    activate_done_o,
  output logic                                    addr_err_o
);

  logic [MATRIX_WIDTH-1:0][MATRIX_WIDTH*8-1:0] pre_q, pre_d;
  logic [MATRIX_WIDTH-1:0]                     sgn_q, sgn_d;
  logic [MATRIX_WIDTH*MATRIX_WIDTH*9-1:0]      act_q, act_d;
  logic [MATRIX_WIDTH-1:0]                     mask_q, mask_d;
  logic                                        done_q, done_d;
  logic                                        err_q, err_d;
  logic                                        addr_ok;

  // The address is compared in 32 bits so that any MATRIX_WIDTH works
  // against the fixed 8-bit row index.
  assign addr_ok = ({24'd0, wei_addr_i} < 32'(MATRIX_WIDTH));

  // Next-state logic. The activate path reads only the registered preweight
  // bank. Because of that, a load in the same cycle lands in preweight but
  // not in the active bank. The mask is cleared by activate before the load
  // sets its own bit, so a combined cycle leaves only the loaded row marked.
  always_comb begin
    pre_d  = pre_q;
    sgn_d  = sgn_q;
    act_d  = act_q;
    mask_d = mask_q;
    err_d  = err_q;
    done_d = 1'b0;

    if (enable_i) begin
      if (activate_i) begin
        for (int r = 0; r < MATRIX_WIDTH; r++) begin
          for (int c = 0; c < MATRIX_WIDTH; c++) begin
            act_d[(r*MATRIX_WIDTH+c)*9 +: 9] =
              {sgn_q[r] & pre_q[r][c*8+7], pre_q[r][c*8 +: 8]};
          end
        end
        mask_d = '0;
        done_d = 1'b1;
      end

      if (load_wei_i) begin
        if (addr_ok) begin
          for (int r = 0; r < MATRIX_WIDTH; r++) begin
            if (wei_addr_i == r[7:0]) begin
              pre_d[r]  = wei_data_i;
              sgn_d[r]  = wei_signed_i;
              mask_d[r] = 1'b1;
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State register. Reset outranks enable and every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q  <= '0;
      sgn_q  <= '0;
      act_q  <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sgn_q  <= sgn_d;
      act_q  <= act_d;
      mask_q <= mask_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign active_wei_o    = act_q;
  assign rows_loaded_o   = mask_q;
  assign full_o          = &mask_q;
  assign activate_done_o = done_q;
  assign addr_err_o      = err_q;

endmodule

// File: tb/tb_cellrv32_npu_weight_receiver.sv
// ---------------------------------------------------------------------------
// tb_cellrv32_npu_weight_receiver
//
// Self-checking bench for the weight receiver, built with MATRIX_WIDTH=4.
// First comes a directed sequence that follows the test plan. After that,
// the bench runs a randomized run. A behavioural model holds weights as
// plain byte arrays and widens each byte with integer arithmetic. Every
// output is compared against this model after each clock edge.
// ---------------------------------------------------------------------------
module tb_cellrv32_npu_weight_receiver;

  localparam int MW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              loadWei;
  logic [7:0]        weiAddr;
  logic              weiSigned;
  logic [MW*8-1:0]   weiData;
  logic              activate;
  logic [MW*MW*9-1:0] activeWei;
  logic [MW-1:0]     rowsLoaded;
  logic              full;
  logic              activateDone;
  logic              addrErr;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model state
  logic [7:0] mPre [MW][MW];
  logic       mSgn [MW];
  logic [8:0] mAct [MW][MW];
  logic [MW-1:0] mMask;
  logic       mDone;
  logic       mErr;

  cellrv32_npu_weight_receiver #(.MATRIX_WIDTH(MW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .load_wei_i      (loadWei),
    .wei_addr_i      (weiAddr),
    .wei_signed_i    (weiSigned),
    .wei_data_i      (weiData),
    .activate_i      (activate),
    .active_wei_o    (activeWei),
    .rows_loaded_o   (rowsLoaded),
    .full_o          (full),
    .activate_done_o (activateDone),
    .addr_err_o      (addrErr)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it
  task automatic checkOutput(input string tag, input logic [MW*MW*9-1:0] obs,
                             input logic [MW*MW*9-1:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Widen one byte to 9 bits through integer value semantics
  function automatic logic [8:0] widen(input logic [7:0] b, input logic s);
    int v;
    v = s ? int'($signed(b)) : int'(b);
    return 9'(v);
  endfunction

  // Advance the model by one clock edge using the current inputs
  task automatic modelStep();
    logic [8:0] nextAct [MW][MW];
    if (rst) begin
      for (int r = 0; r < MW; r++) begin
        mSgn[r] = 1'b0;
        for (int c = 0; c < MW; c++) begin
          mPre[r][c] = 8'h00;
          mAct[r][c] = 9'h000;
        end
      end
      mMask = '0;
      mDone = 1'b0;
      mErr  = 1'b0;
    end else if (!enable) begin
      mDone = 1'b0;
    end else begin
      for (int r = 0; r < MW; r++)
        for (int c = 0; c < MW; c++)
          nextAct[r][c] = activate ? widen(mPre[r][c], mSgn[r]) : mAct[r][c];
      mAct  = nextAct;
      mDone = activate;
      if (activate) mMask = '0;
      if (loadWei) begin
        if (int'(weiAddr) < MW) begin
          for (int c = 0; c < MW; c++) mPre[weiAddr][c] = weiData[c*8 +: 8];
          mSgn[weiAddr]  = weiSigned;
          mMask[weiAddr] = 1'b1;
        end else begin
          mErr = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [MW*MW*9-1:0] flatAct();
    logic [MW*MW*9-1:0] f;
    for (int r = 0; r < MW; r++)
      for (int c = 0; c < MW; c++)
        f[(r*MW+c)*9 +: 9] = mAct[r][c];
    return f;
  endfunction

  // Drive one cycle of inputs, clock it, then compare all outputs
  task automatic applyStimulus(input logic r, input logic en, input logic ld,
                               input logic [7:0] addr, input logic sg,
                               input logic [MW*8-1:0] data, input logic act);
    rst = r; enable = en; loadWei = ld; weiAddr = addr;
    weiSigned = sg; weiData = data; activate = act;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("active_wei", activeWei, flatAct());
    checkOutput("rows_loaded", {{(MW*MW*9-MW){1'b0}}, rowsLoaded},
                {{(MW*MW*9-MW){1'b0}}, mMask});
    checkOutput("full", {{(MW*MW*9-1){1'b0}}, full},
                {{(MW*MW*9-1){1'b0}}, (mMask == {MW{1'b1}})});
    checkOutput("activate_done", {{(MW*MW*9-1){1'b0}}, activateDone},
                {{(MW*MW*9-1){1'b0}}, mDone});
    checkOutput("addr_err", {{(MW*MW*9-1){1'b0}}, addrErr},
                {{(MW*MW*9-1){1'b0}}, mErr});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    for (int r = 0; r < MW; r++) begin
      mSgn[r] = 1'b0;
      for (int c = 0; c < MW; c++) begin
        mPre[r][c] = 8'h00;
        mAct[r][c] = 9'h000;
      end
    end
    mMask = '0; mDone = 1'b0; mErr = 1'b0;

    // Reset
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, '0, 1'b0);
    idle();

    // Signed 0x81 rows, mask fills, then activate
    for (int r = 0; r < MW; r++)
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(r), 1'b1, 32'h81818181, 1'b0);
    checkOutput("full_after_row3", {{(MW*MW*9-1){1'b0}}, full},
                {{(MW*MW*9-1){1'b0}}, 1'b1});
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b1);
    checkOutput("signed_elem", {135'd0, activeWei[8:0]}, {135'd0, 9'h181});
    idle();

    // Unsigned 0x81 rows
    for (int r = 0; r < MW; r++)
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(r), 1'b0, 32'h81818181, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b1);
    checkOutput("unsigned_elem", {135'd0, activeWei[8:0]}, {135'd0, 9'h081});

    // Mixed: only row 2 signed
    for (int r = 0; r < MW; r++)
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(r), (r == 2), 32'h81818181, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b1);
    checkOutput("mixed_row2", {135'd0, activeWei[(2*MW)*9 +: 9]}, {135'd0, 9'h181});
    checkOutput("mixed_row1", {135'd0, activeWei[(1*MW)*9 +: 9]}, {135'd0, 9'h081});

    // Load + activate in the same cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 32'h05050505, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 32'h07070707, 1'b1);
    checkOutput("overlap_row1", {135'd0, activeWei[(1*MW)*9 +: 9]}, {135'd0, 9'h005});
    checkOutput("overlap_mask", {140'd0, rowsLoaded}, {140'd0, 4'b0010});
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b1);
    checkOutput("second_act_row1", {135'd0, activeWei[(1*MW)*9 +: 9]}, {135'd0, 9'h007});

    // Bad addresses, then a valid load
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 32'hCAFEF00D, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 32'h11223344, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b1);

    // Stall with load and activate asserted, then release
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 32'h80808080, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 32'h80808080, 1'b1);
    idle();

    // Reset during a load discards everything
    for (int r = 0; r < 3; r++)
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(r), 1'b1, 32'hA5A5A5A5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 32'hA5A5A5A5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, '0, 1'b1);
    checkOutput("post_reset_zero", activeWei, '0);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 1) == 1),
                    8'($urandom_range(0, 5)),
                    ($urandom_range(0, 1) == 1),
                    32'($urandom()),
                    ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
